// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column low at a time, debounces press and
// release on the latched row, and reports one key code per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 2);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] DEB_ONE    = CW'(1);
  localparam logic [CW-1:0] DEB_ZERO   = CW'(0);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [3:0]    row_meta_r;
  logic [3:0]    row_sync_r;
  logic [DW-1:0] dwell_r;
  logic [CW-1:0] deb_cnt_r;
  logic [1:0]    row_idx_r;
  logic [1:0]    col_idx_r;

  logic          tick_s;
  logic          any_low_s;
  logic          latched_low_s;
  logic [1:0]    row_sel_s;
  logic [CW-1:0] deb_next_s;

  // Two-flop synchronizer for the asynchronous row lines; idles at "no key".
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= row_n;
      row_sync_r <= row_meta_r;
    end
  end

  // Column dwell counter; the sample tick is its last count.
  always_ff @(posedge clk) begin
    if (reset || tick_s) begin
      dwell_r <= '0;
    end else begin
      dwell_r <= dwell_r + DW'(1);
    end
  end

  // Tick decode and lowest-index-low-row priority select.
  always_comb begin
    tick_s        = (dwell_r == DWELL_LAST);
    any_low_s     = (row_sync_r != 4'b1111);
    latched_low_s = ~row_sync_r[row_idx_r];
    deb_next_s    = deb_cnt_r + DEB_ONE;
    if (!row_sync_r[0]) begin
      row_sel_s = 2'd0;
    end else if (!row_sync_r[1]) begin
      row_sel_s = 2'd1;
    end else if (!row_sync_r[2]) begin
      row_sel_s = 2'd2;
    end else begin
      row_sel_s = 2'd3;
    end
  end

  // Scan/debounce FSM with registered strobes and key outputs; only acts on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= SCAN;
      col_n     <= 4'b1110;
      col_idx_r <= 2'd0;
      row_idx_r <= 2'd0;
      deb_cnt_r <= DEB_ZERO;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick_s) begin
        case (state_r)
          SCAN: begin
            if (any_low_s) begin
              row_idx_r <= row_sel_s;
              deb_cnt_r <= DEB_ONE;
              if (DEBOUNCE_CNT == 1) begin
                state_r   <= PRESSED;
                key_code  <= {row_sel_s, col_idx_r};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state_r <= DEBOUNCE;
              end
            end else begin
              col_n     <= {col_n[2:0], col_n[3]};
              col_idx_r <= col_idx_r + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (latched_low_s) begin
              deb_cnt_r <= deb_next_s;
              if (deb_next_s >= DEB_TARGET) begin
                state_r   <= PRESSED;
                key_code  <= {row_idx_r, col_idx_r};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else begin
              state_r   <= SCAN;
              deb_cnt_r <= DEB_ZERO;
              col_n     <= {col_n[2:0], col_n[3]};
              col_idx_r <= col_idx_r + 2'd1;
            end
          end
          PRESSED: begin
            if (!latched_low_s) begin
              deb_cnt_r <= DEB_ONE;
              state_r   <= RELEASE;
            end
          end
          RELEASE: begin
            if (!latched_low_s) begin
              deb_cnt_r <= deb_next_s;
              // A single stray low sample sends us back without a new press event.
              if (deb_next_s >= DEB_TARGET) begin
                state_r   <= SCAN;
                deb_cnt_r <= DEB_ZERO;
                key_held  <= 1'b0;
                col_n     <= {col_n[2:0], col_n[3]};
                col_idx_r <= col_idx_r + 2'd1;
              end
            end else begin
              state_r   <= PRESSED;
              deb_cnt_r <= DEB_ZERO;
            end
          end
          default: begin
            state_r <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random key activity,
// checked every cycle against a tick-level behavioural keypad model.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dut_pulses = 0;
  int exp_pulses = 0;

  // keypad environment
  logic [15:0] pressed = 16'h0;
  bit          raw_mode = 1'b0;
  logic [3:0]  raw_rows = 4'hF;

  // reference model: column being scanned, press/release run lengths, latched key
  int         m_col, m_n, m_row, m_run, m_rel;
  bit         m_track, m_held;
  logic [3:0] d1, d2;
  logic [3:0] e_code;
  logic       e_valid, e_held;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input int col);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (keys[i*4+col]) r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic accept();
    m_held  = 1'b1;
    m_track = 1'b0;
    m_rel   = 0;
    e_valid = 1'b1;
    e_held  = 1'b1;
    e_code  = 4'(m_row * 4 + m_col);
    exp_pulses++;
  endtask

  task automatic model_edge(input bit rst, input logic [3:0] rin);
    logic [3:0] s;
    bit tick;
    if (rst) begin
      m_col = 0; m_n = 0; m_row = 0; m_run = 0; m_rel = 0;
      m_track = 1'b0; m_held = 1'b0;
      d1 = 4'hF; d2 = 4'hF;
      e_code = 4'h0; e_valid = 1'b0; e_held = 1'b0;
    end else begin
      s  = d2;
      d2 = d1;
      d1 = rin;
      tick = ((m_n % SD) == SD - 1);
      m_n++;
      e_valid = 1'b0;
      if (tick) begin
        if (m_held) begin
          if (s[m_row]) begin
            m_rel++;
            if (m_rel >= DB) begin
              m_held = 1'b0;
              e_held = 1'b0;
              m_col  = (m_col + 1) % 4;
            end
          end else begin
            m_rel = 0;
          end
        end else if (m_track) begin
          if (!s[m_row]) begin
            m_run++;
            if (m_run >= DB) accept();
          end else begin
            m_track = 1'b0;
            m_col   = (m_col + 1) % 4;
          end
        end else if (s != 4'hF) begin
          for (int i = 3; i >= 0; i--) begin
            if (!s[i]) m_row = i;
          end
          m_track = 1'b1;
          m_run   = 1;
          if (m_run >= DB) accept();
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0] rin;
    bit rst;
    rin = row_n;
    rst = reset;
    @(posedge clk);
    model_edge(rst, rin);
    cyc++;
    #1;
    if (key_valid === 1'b1) dut_pulses++;
    chk("col_n",     {4'h0, col_n},    {4'h0, ~(4'b0001 << m_col)});
    chk("key_valid", {7'h0, key_valid}, {7'h0, e_valid});
    chk("key_held",  {7'h0, key_held},  {7'h0, e_held});
    chk("key_code",  {4'h0, key_code}, {4'h0, e_code});
    row_n = raw_mode ? raw_rows : keypad_rows(pressed, m_col);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int p0;

  initial begin
    reset = 1'b1;
    row_n = 4'hF;
    run(2);
    reset = 1'b0;
    chk("reset_col_n", {4'h0, col_n}, 8'h0E);
    chk("reset_held",  {7'h0, key_held}, 8'h00);

    // idle: full column rotation, no key events
    run(40);
    chk("idle_pulses", 8'(dut_pulses), 8'h00);

    // key at row1/col2 held stable
    reset = 1'b1; run(1); reset = 1'b0;
    p0 = dut_pulses;
    pressed = 16'h0040;
    run(60);
    chk("k6_pulses", 8'(dut_pulses - p0), 8'h01);
    chk("k6_code",   {4'h0, key_code}, 8'h06);
    chk("k6_col",    {4'h0, col_n}, 8'h0B);
    // release glitch of two ticks, then pressed again
    pressed = 16'h0000;
    run(16);
    pressed = 16'h0040;
    run(40);
    chk("glitch_held",   {7'h0, key_held}, 8'h01);
    chk("glitch_pulses", 8'(dut_pulses - p0), 8'h01);
    pressed = 16'h0000;
    run(40);
    chk("k6_released", {7'h0, key_held}, 8'h00);

    // one-tick bounce on row0
    p0 = dut_pulses;
    raw_mode = 1'b1;
    raw_rows = 4'b1110;
    row_n = raw_rows;
    run(8);
    raw_rows = 4'b1111;
    row_n = raw_rows;
    run(32);
    raw_mode = 1'b0;
    chk("bounce_pulses", 8'(dut_pulses - p0), 8'h00);

    // rows 0 and 3 low on col0, then other keys while locked
    p0 = dut_pulses;
    pressed = 16'h1001;
    run(80);
    chk("multi_code",   {4'h0, key_code}, 8'h00);
    chk("multi_pulses", 8'(dut_pulses - p0), 8'h01);
    pressed = 16'h1031;
    run(40);
    chk("locked_pulses", 8'(dut_pulses - p0), 8'h01);
    chk("locked_col",    {4'h0, col_n}, 8'h0E);
    pressed = 16'h0000;
    run(60);

    // reset while pressed with the key still held
    reset = 1'b1; run(1); reset = 1'b0;
    pressed = 16'h0001;
    run(40);
    chk("pre_reset_held", {7'h0, key_held}, 8'h01);
    p0 = dut_pulses;
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    chk("mid_reset_col",   {4'h0, col_n}, 8'h0E);
    chk("mid_reset_held",  {7'h0, key_held}, 8'h00);
    chk("mid_reset_valid", {7'h0, key_valid}, 8'h00);
    chk("mid_reset_code",  {4'h0, key_code}, 8'h00);
    run(40);
    chk("redetect_pulses", 8'(dut_pulses - p0), 8'h01);
    pressed = 16'h0000;
    run(40);

    // random key activity including short bounces and chords
    for (int t = 0; t < 120; t++) begin
      case ($urandom_range(0, 3))
        0: pressed = 16'h0000;
        1: pressed = 16'(1) << $urandom_range(0, 15);
        2: pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: pressed = pressed;
      endcase
      run($urandom_range(4, 60));
    end
    pressed = 16'h0000;
    run(60);
    chk("total_pulses", 8'(dut_pulses), 8'(exp_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
